// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub/slt ops plus an iterative shift-add multiply.
// Optional MC_ALU_MUL_EARLY_EN ends the multiply as soon as the remaining multiplier bits are all zero.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       gin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] comb_res;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mplier_nx;
  logic [CW-1:0]    cnt_nx;
  logic             mul_fin;

  always_comb begin
    comb_res = '0;
    case (gin)
      3'b010:  comb_res = a + b;
      3'b110:  comb_res = a - b;
      3'b000:  comb_res = a & b;
      3'b001:  comb_res = a | b;
      3'b100:  comb_res = ~(a | b);
      3'b111:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: comb_res = '0;
    endcase
  end

  // One shift-add step of the multiply, evaluated every MUL cycle.
  always_comb begin
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_nx = mplier_q >> 1;
    cnt_nx    = cnt_q + CW'(1);
`ifdef MC_ALU_MUL_EARLY_EN
    mul_fin   = (cnt_nx == CW'(WIDTH)) || (mplier_nx == '0);
`else
    mul_fin   = (cnt_nx == CW'(WIDTH));
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (gin == 3'b011) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = comb_res;
            done_d   = 1'b1;
          end
        end
      end
      default: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nx;
        cnt_d    = cnt_nx;
        if (mul_fin) begin
          result_d = acc_step;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == S_MUL);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = (result_q == '0);
endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu: driver pushes expected result and completion cycle, monitor checks on done.
module tb_mc_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   gin;
  logic [W-1:0] a, b;
  logic         busy, done, zero;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  mc_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .gin(gin), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'b0, zero}, {31'b0, (e.res == '0)});
        chk("done_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  // Drive one request at a negedge; lat is the number of edges after the capture edge until done.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input bit push, input logic [W-1:0] exp_res, input int lat);
    int c0;
    exp_t e;
    start = 1'b1; gin = op; a = ia; b = ib;
    c0 = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.res = exp_res;
      e.cyc = c0 + lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no done within %0d cycles expected a completion", max_cyc);
    end
  endtask

  function automatic int mul_lat(input logic [W-1:0] mb);
`ifdef MC_ALU_MUL_EARLY_EN
    int l = 1;
    for (int i = 0; i < W; i++) if (mb[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  initial begin
    reset = 1'b1; start = 1'b1; gin = 3'b010; a = 32'd1; b = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, '0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    // Single-cycle ops issued back-to-back.
    issue(3'b010, 32'h0000000F, 32'h000000F0, 1, 32'h000000FF, 0);
    issue(3'b110, 32'h0000000F, 32'h000000F0, 1, 32'hFFFFFF1F, 0);
    issue(3'b000, 32'h0000000F, 32'h000000F0, 1, 32'h00000000, 0);
    issue(3'b001, 32'h0000000F, 32'h000000F0, 1, 32'h000000FF, 0);
    issue(3'b100, 32'h0000000F, 32'h000000F0, 1, 32'hFFFFFF00, 0);
    issue(3'b101, 32'h0000000F, 32'h000000F0, 1, 32'h00000000, 0);
    issue(3'b111, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000001, 0);
    issue(3'b111, 32'h00000001, 32'hFFFFFFFF, 1, 32'h00000000, 0);
    @(negedge clk);

    issue(3'b011, 32'd1234, 32'd5678, 1, 32'd7006652, mul_lat(32'd5678));
    @(negedge clk);
    chk("mul_busy", {31'b0, busy}, 32'd1);
    // Start with a logic op while busy must be dropped.
    start = 1'b1; gin = 3'b000; a = '0; b = '0;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    // Back-to-back: issue in the done cycle.
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001, mul_lat(32'hFFFFFFFF));
    wait_done(40);
    chk("idle_after_mul", {31'b0, busy}, 32'd0);
    issue(3'b011, 32'd3, 32'd5, 1, 32'd15, mul_lat(32'd5));
    wait_done(40);
    issue(3'b011, 32'd77, 32'd0, 1, 32'd0, mul_lat(32'd0));
    wait_done(40);
    issue(3'b010, 32'hFFFFFFFF, 32'h00000002, 1, 32'h00000001, 0);
    @(negedge clk);

    // Reset in the middle of a full-length multiply.
    issue(3'b011, 32'd1234, 32'hFFFFFFFF, 0, '0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_result", result, '0);
    chk("abort_zero", {31'b0, zero}, 32'd1);
    chk("abort_done", {31'b0, done}, 32'd0);
    repeat (40) @(negedge clk);

    chk("sb_empty", W'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
